// File: rtl/hilo_div_ctrl.sv
// Multi-cycle restoring unsigned divider that owns the HI/LO registers and drives pipeline stalls.
// Optional macro HILO_DIV_ZERO_FAST_EN: a zero divisor completes one edge after capture.
module hilo_div_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             mf_req,
  input  logic             mf_sel,
  output logic [WIDTH-1:0] mf_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic             dz
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q, r, d;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] r_next, q_next;
  logic             take, fast_zero, last;

  // One restoring step; the shifted remainder carries an extra bit so the compare cannot overflow.
  always_comb begin
    r_sh   = {r, q[WIDTH-1]};
    take   = r_sh >= {1'b0, d};
    r_next = take ? (r_sh[WIDTH-1:0] - d) : r_sh[WIDTH-1:0];
    q_next = {q[WIDTH-2:0], take};
  end

`ifdef HILO_DIV_ZERO_FAST_EN
  assign fast_zero = (d == '0);
`else
  assign fast_zero = 1'b0;
`endif

  assign last    = (cnt == CNT_W'(1));
  assign busy    = (state == BUSY);
  assign mf_data = mf_sel ? hi : lo;
  // Second term: DIVU in EX and MFHI/MFLO in ID arriving together while idle.
  assign stall   = (busy & (mf_req | start)) | (start & ~busy & mf_req);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = BUSY;
      BUSY: if (last || fast_zero) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      q    <= '0;
      r    <= '0;
      d    <= '0;
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
      dz   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          q   <= dividend;
          d   <= divisor;
          r   <= '0;
          cnt <= CNT_W'(WIDTH);
        end
      end else if (fast_zero) begin
        // q still holds the untouched dividend here
        hi   <= q;
        lo   <= '1;
        dz   <= 1'b1;
        done <= 1'b1;
        cnt  <= '0;
      end else begin
        r   <= r_next;
        q   <= q_next;
        cnt <= cnt - CNT_W'(1);
        if (last) begin
          hi   <= r_next;
          lo   <= q_next;
          dz   <= (d == '0);
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/hilo_div_ctrl.md
# hilo_div_ctrl

Multi-cycle unsigned divide sequencer and HI/LO register owner for the `mips_pipeline` core. It accepts DIVU from the EX stage and runs a restoring shift-subtract divider, one quotient bit per cycle. It holds the results in the architectural HI and LO registers and serves MFHI and MFLO reads. It also drives a pipeline stall whenever a HI/LO read or a second DIVU would race an unfinished divide.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width.
- `CNT_W`, default 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.
- `clk`  in  1: rising-edge clock; the only clock.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: DIVU valid in EX this cycle.
- `dividend`  in  WIDTH: rs value, sampled with `start`.
- `divisor`  in  WIDTH: rt value, sampled with `start`.
- `mf_req`  in  1: MFHI or MFLO decoded in ID this cycle.
- `mf_sel`  in  1: 1 selects HI, 0 selects LO.
- `mf_data`  out  WIDTH: combinational `mf_sel ? hi : lo`.
- `hi`  out  WIDTH: HI register, holding the remainder.
- `lo`  out  WIDTH: LO register, holding the quotient.
- `busy`  out  1: divide in progress.
- `done`  out  1: one-cycle pulse after HI/LO update.
- `stall`  out  1: combinational; the pipeline must freeze IF/ID/EX when this is high.
- `dz`  out  1: registered; set when the divide that last completed had divisor 0.

## Operation
- States: IDLE and BUSY.
- IDLE:
  - `start`=1 latches `dividend` into the quotient shift register `q`.
  - It latches `divisor` into `d`, clears the partial remainder `r`, loads `cnt`=WIDTH and moves to BUSY.
- BUSY iteration, once per cycle:
  - `{r,q} <= {r,q} << 1`.
  - If shifted `r` ≥ `d`, subtract `d` from `r` and set `q[0]`=1.
  - `cnt` decrements. The comparison uses WIDTH+1 bits so there is no overflow.
- Last iteration (`cnt`==1): in the same edge, `hi<=r_final`, `lo<=q_final`, `dz<=(d==0)`, `done<=1`, and the state returns to IDLE.
- `start` while BUSY is ignored by the sequencer. `stall` holds the pipeline so the DIVU stays in EX until it is accepted.
- Divisor 0 without the fast path needs no special case: the algorithm naturally yields LO=all ones and HI=dividend.
- `stall` = `busy` & (`mf_req` | `start`), OR `start` & IDLE & `mf_req`.
  - The second term covers a DIVU in EX with an MFHI/MFLO in ID in the same cycle.
- HI/LO change only at completion and at reset.
- `mf_data` reflects the registers combinationally. A read in the `done` cycle returns the new values.
- Reset is asynchronous and may arrive mid-operation. It forces IDLE and clears `cnt`, `q`, `r`, `d`, `hi`, `lo`, `busy`, `done` and `dz` to 0. The in-flight divide is discarded.

## Timing
- Edge E0 (IDLE, `start`=1): operands are captured and `busy`=1 from E0 onward.
- Edges E1..E_WIDTH: iterations run. HI/LO are written at E_WIDTH.
- `busy` stays high for WIDTH cycles and falls at E_WIDTH.
- `done` is high for exactly the cycle following E_WIDTH.
- DIVU-to-result latency is WIDTH+1 edges including the capture edge.
- A back-to-back DIVU is stalled until IDLE and is accepted at E_WIDTH+1 at the earliest.
- An MFHI issued in the cycle of E0 stalls WIDTH+1 cycles and reads the new HI in the `done` cycle.
- `done`, `dz`, `hi` and `lo` are registered. `stall` and `mf_data` are combinational.

## Configuration
- `HILO_DIV_ZERO_FAST_EN` defined:
  - If the captured divisor is 0, the sequencer completes at E1 with `hi`=dividend, `lo`={WIDTH{1}}, `dz`=1.
  - `busy` is high for one cycle and `done` pulses in the cycle after E1.
- Not defined: a zero divisor runs the full WIDTH iterations. Final values are identical, including `dz`=1.

## Test plan
- Reset, then DIVU 100/7 → after 33 edges `lo`=14, `hi`=2, `dz`=0, one `done` pulse, `busy` high for exactly 32 cycles.
- DIVU 0xFFFFFFFF/1, then MFLO in ID during BUSY → `stall` high until IDLE, then `mf_data`=0xFFFFFFFF and `hi`=0.
- DIVU 5/0 → `lo`=0xFFFFFFFF, `hi`=5, `dz`=1. Done arrives after 2 edges with `HILO_DIV_ZERO_FAST_EN` defined, and after 33 edges without it.
- DIVU 9/4 immediately followed by DIVU 20/3 held in EX → first result `lo`=2, `hi`=1. The second is accepted at E33, giving `lo`=6, `hi`=2. `stall` is high for all 32 busy cycles.
- Same-cycle `start` and `mf_req` from IDLE → `stall`=1 in that cycle.
- Reset at busy cycle 10 of 1000/10 → all outputs 0 immediately, `done` never pulses. A new DIVU 1000/10 afterwards gives `lo`=100, `hi`=0.
